// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch PC, instruction memory requests and prefetch queue feeding the controller
module inst_fetch_unit #(
  parameter int PC_W  = 8,
  parameter int IR_W  = 16,
  parameter int DEPTH = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  output logic            IM_Req,
  output logic [PC_W-1:0] IM_Addr,
  input  logic            IM_Ack,
  input  logic [IR_W-1:0] IM_Data,
  output logic            Fetch_Ready,
  input  logic            Fetch_Take,
  output logic [IR_W-1:0] IR_Out,
  output logic [PC_W-1:0] PC_Out,
  input  logic            Jump_En,
  input  logic [PC_W-1:0] Jump_Addr,
  input  logic            Halt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2;
  logic [1:0] state, state_n;
  logic [PC_W-1:0] fetch_pc, fetch_pc_n, drain_addr;
  logic [IR_W+PC_W-1:0] mem [DEPTH];
  logic [IR_W+PC_W-1:0] head_n;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_n, remain;
  logic take, ack, wr, go;
  assign IM_Req      = state != IDLE;
  // during DRAIN the old address stays on the bus while fetch_pc already holds the target
  assign IM_Addr     = state == DRAIN ? drain_addr : fetch_pc;
  assign Fetch_Ready = count != '0;
  assign take    = Fetch_Take && Fetch_Ready;
  assign ack     = IM_Req && IM_Ack;
  assign wr      = ack && state == REQ && !Jump_En;
  assign remain  = count - CW'(take);
  assign count_n = Jump_En ? '0 : remain + CW'(wr);
  assign go      = !Halt && count_n < CW'(DEPTH);
  assign fetch_pc_n = Jump_En ? Jump_Addr : wr ? fetch_pc + PC_W'(1) : fetch_pc;
  assign state_n = (state == IDLE || ack) ? (go ? REQ : IDLE) : (Jump_En ? DRAIN : state);
  // head register: next surviving entry, else the bypassed write, else hold the last value
  assign head_n = Jump_En ? {IR_Out, PC_Out}
                : remain != '0 ? mem[rd_ptr + AW'(take)]
                : wr ? {IM_Data, IM_Addr} : {IR_Out, PC_Out};
  always_ff @(posedge Clk) begin
    if (wr) mem[wr_ptr] <= {IM_Data, IM_Addr};
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      fetch_pc   <= '0;
      drain_addr <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      IR_Out     <= '0;
      PC_Out     <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      if (state_n == DRAIN) drain_addr <= IM_Addr;
      rd_ptr   <= Jump_En ? '0 : rd_ptr + AW'(take);
      wr_ptr   <= Jump_En ? '0 : wr_ptr + AW'(wr);
      count    <= count_n;
      {IR_Out, PC_Out} <= head_n;
    end
  end
endmodule
